// File: rtl/bcd_divisibility_seq.sv
// Streaming BCD divisibility checker: MSD-first digits over valid/ready, running remainder mod DIVISOR.
// Optional feature macro: BCD_DIV_ERRCHK_EN (reject digits above 9 and abort the transaction).
module bcd_divisibility_seq #(
  parameter  int DIGITS  = 4,
  parameter  int DIVISOR = 11,
  localparam int RW      = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [3:0]    DIGIT_IN,
  input  logic          DIGIT_VALID,
  output logic          DIGIT_READY,
  output logic          DONE,
  output logic          DIVISIBLE,
  output logic [RW-1:0] REMAINDER,
  output logic          INVALID
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [RW+3:0] TEN   = (RW + 4)'(10);
  localparam logic [RW+3:0] DIV_W = (RW + 4)'(DIVISOR);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 32) begin : g_bad_digits
    $error("bcd_divisibility_seq: DIGITS must be 1..32");
  end
  if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
    $error("bcd_divisibility_seq: DIVISOR must be 2..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] remainder_q, remainder_d;
  logic          divisible_q, divisible_d;

  logic          xfer;
  logic          last_digit;
  logic [RW+3:0] acc;
  logic [RW+3:0] acc_mod;
  logic [RW-1:0] rem_next;

`ifdef BCD_DIV_ERRCHK_EN
  logic invalid_q, invalid_d;
  logic digit_bad;

  assign digit_bad = (DIGIT_IN > 4'd9);
  assign INVALID   = invalid_q;
`else
  assign INVALID   = 1'b0;
`endif

  assign DIGIT_READY = (state_q == ACCEPT);
  assign DONE        = (state_q == FINISH);
  assign DIVISIBLE   = divisible_q;
  assign REMAINDER   = remainder_q;

  assign xfer       = DIGIT_VALID && DIGIT_READY;
  assign last_digit = (cnt_q == LAST_IDX);

  // r*10 + digit always fits in RW+4 bits, so the modulo needs no wider datapath.
  always_comb begin
    acc      = ({4'b0000, rem_q} * TEN) + {{RW{1'b0}}, DIGIT_IN};
    acc_mod  = acc % DIV_W;
    rem_next = acc_mod[RW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    remainder_d = remainder_q;
    divisible_d = divisible_q;
`ifdef BCD_DIV_ERRCHK_EN
    invalid_d   = invalid_q;
`endif

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d     = ACCEPT;
          rem_d       = '0;
          cnt_d       = '0;
          remainder_d = '0;
          divisible_d = 1'b0;
`ifdef BCD_DIV_ERRCHK_EN
          invalid_d   = 1'b0;
`endif
        end
      end

      ACCEPT: begin
        if (xfer) begin
          rem_d = rem_next;
          cnt_d = cnt_q + CW'(1);
`ifdef BCD_DIV_ERRCHK_EN
          if (digit_bad) begin
            state_d     = FINISH;
            invalid_d   = 1'b1;
            remainder_d = '0;
            divisible_d = 1'b0;
          end else
`endif
          if (last_digit) begin
            state_d     = FINISH;
            remainder_d = rem_next;
            divisible_d = (rem_next == '0);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      cnt_q       <= '0;
      remainder_q <= '0;
      divisible_q <= 1'b0;
`ifdef BCD_DIV_ERRCHK_EN
      invalid_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      remainder_q <= remainder_d;
      divisible_q <= divisible_d;
`ifdef BCD_DIV_ERRCHK_EN
      invalid_q   <= invalid_d;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_divisibility_seq.sv
// Scoreboard bench for bcd_divisibility_seq: a divide-by-11 and a divide-by-7 instance share one stimulus stream.
// Expected results are hand-computed per number and queued; a monitor checks them on every DONE.
module tb_bcd_divisibility_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] digit_in;
  logic       digit_valid;

  logic       ready11, done11, div11, inv11;
  logic [3:0] rem11;
  logic       ready7, done7, div7, inv7;
  logic [2:0] rem7;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] r11;
    logic [2:0] r7;
    logic       d11;
    logic       d7;
    logic       inv;
    int         done_cyc;
  } exp_t;

  exp_t exp_q[$];

  bcd_divisibility_seq #(.DIGITS(4), .DIVISOR(11)) dut11 (
    .CLK(clk), .RST(rst), .START(start), .DIGIT_IN(digit_in), .DIGIT_VALID(digit_valid),
    .DIGIT_READY(ready11), .DONE(done11), .DIVISIBLE(div11), .REMAINDER(rem11), .INVALID(inv11)
  );

  bcd_divisibility_seq #(.DIGITS(4), .DIVISOR(7)) dut7 (
    .CLK(clk), .RST(rst), .START(start), .DIGIT_IN(digit_in), .DIGIT_VALID(digit_valid),
    .DIGIT_READY(ready7), .DONE(done7), .DIVISIBLE(div7), .REMAINDER(rem7), .INVALID(inv7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DONE from either instance must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done11 === 1'b1 || done7 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("done_cycle", cyc, e.done_cyc);
        checkOutput("done11", done11, 1);
        checkOutput("done7", done7, 1);
        checkOutput("divisible11", div11, e.d11);
        checkOutput("remainder11", rem11, e.r11);
        checkOutput("divisible7", div7, e.d7);
        checkOutput("remainder7", rem7, e.r7);
        checkOutput("invalid11", inv11, e.inv);
        checkOutput("invalid7", inv7, e.inv);
      end
    end
  end

  // Presents a digit and waits (bounded) for the handshake; returns at the negedge before the transfer edge.
  task automatic sendDigit(input logic [3:0] d);
    int t;
    digit_valid = 1'b1;
    digit_in    = d;
    t = 0;
    while (ready11 !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    checkOutput("digit_ready", ready11, 1);
    checkOutput("digit_ready7", ready7, 1);
  endtask

  task automatic applyStimulus(input logic [15:0] num, input int ndig, input int gap,
                               input logic [3:0] r11, input logic [2:0] r7,
                               input logic d11, input logic d7, input logic inv, input bit hold);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < ndig; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      sendDigit(num[15-4*i -: 4]);
      if (i == ndig - 1) begin
        e.r11 = r11; e.r7 = r7; e.d11 = d11; e.d7 = d7; e.inv = inv;
        e.done_cyc = cyc + 1;
        exp_q.push_back(e);
      end
      @(negedge clk);
      digit_valid = 1'b0;
      digit_in    = 4'hF;
    end
    if (hold) begin
      @(negedge clk);
      checkOutput("hold_ready", ready11, 0);
      checkOutput("hold_remainder11", rem11, r11);
      checkOutput("hold_divisible11", div11, d11);
      checkOutput("hold_remainder7", rem7, r7);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; digit_in = 4'h0; digit_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", ready11, 0);
    checkOutput("reset_done", done11, 0);
    checkOutput("reset_divisible", div11, 0);
    checkOutput("reset_remainder", rem11, 0);
    checkOutput("reset_invalid", inv11, 0);

    //             num     nd gap r11   r7    d11   d7    inv   hold
    applyStimulus(16'h0000, 4, 0, 4'd0,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h9867, 4, 0, 4'd0,  3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h9998, 4, 0, 4'd10, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h0012, 4, 0, 4'd1,  3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0022, 4, 3, 4'd0,  3'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h9999, 4, 1, 4'd0,  3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h1234, 4, 0, 4'd2,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef BCD_DIV_ERRCHK_EN
    applyStimulus(16'h1A00, 2, 0, 4'd0,  3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
`else
    applyStimulus(16'h1A00, 4, 0, 4'd9,  3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Mid-transaction reset after two digits: no DONE may follow and outputs must clear.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sendDigit(4'd9);
      @(negedge clk);
      digit_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready", ready11, 0);
    checkOutput("midrst_done", done11, 0);
    checkOutput("midrst_divisible", div11, 0);
    checkOutput("midrst_remainder", rem11, 0);
    checkOutput("midrst_invalid", inv11, 0);
    repeat (6) @(negedge clk);

    applyStimulus(16'h0033, 4, 0, 4'd0,  3'd5, 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
